// File: rtl/watchdog_kicker.sv
// Heartbeat source for a system watchdog: periodic kick pulses while all health
// inputs are OK, latched fault after repeated misses, latched shutdown on WDT timeout.
module watchdog_kicker #(
  parameter int CLK_HZ       = 24000000,
  parameter int KICK_MS      = 100,
  parameter int PULSE_CYCLES = 4,
  parameter int FAULT_LIMIT  = 3,
  parameter int N_HEALTH     = 4,
  localparam int KICK_RAW    = (CLK_HZ / 1000) * KICK_MS,
  localparam int KICK_CNT    = (KICK_RAW < 1) ? 1 : KICK_RAW,
  localparam int CNT_W       = (KICK_CNT > 1) ? $clog2(KICK_CNT) : 1,
  localparam int PC_W        = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1,
  localparam int MISS_W      = $clog2(FAULT_LIMIT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [N_HEALTH-1:0] health_ok,
  input  logic                wdt_timeout,
  input  logic                clear,
  output logic                kick,
  output logic                shutdown_req,
  output logic                fault,
  output logic [1:0]          state,
  output logic [MISS_W-1:0]   miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_FAULT    = 2'd2,
    S_SHUTDOWN = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(KICK_CNT - 1);
  localparam logic [PC_W-1:0]   PC_LOAD   = PC_W'(PULSE_CYCLES - 1);
  localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(FAULT_LIMIT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_nxt;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
  logic                pend_q, pend_d;
  logic                kick_q, kick_d;
  logic                fault_q, fault_d;
  logic                shut_q, shut_d;
  logic [N_HEALTH-1:0] h_s1_q, h_s2_q;
  logic                wdt_s1_q, wdt_s2_q, wdt_s3_q;
  logic                healthy, to_rise, term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_s1_q   <= '0;
      h_s2_q   <= '0;
      wdt_s1_q <= 1'b0;
      wdt_s2_q <= 1'b0;
      wdt_s3_q <= 1'b0;
    end else begin
      h_s1_q   <= health_ok;
      h_s2_q   <= h_s1_q;
      wdt_s1_q <= wdt_timeout;
      wdt_s2_q <= wdt_s1_q;
      wdt_s3_q <= wdt_s2_q;
    end
  end

  assign healthy  = &h_s2_q;
  assign to_rise  = wdt_s2_q & ~wdt_s3_q;
  assign cnt_nxt  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
  // Terminal event is decided on the edge where the counter reaches KICK_CNT-1;
  // the kick itself is launched one edge later through pend_q.
  assign term     = (cnt_nxt == CNT_MAX);
  assign miss_inc = miss_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    miss_d  = miss_q;
    pend_d  = 1'b0;
    kick_d  = 1'b0;
    fault_d = fault_q;
    shut_d  = shut_q;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        pc_d   = '0;
        miss_d = '0;
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_nxt;
        if (kick_q && pc_q != '0) begin
          kick_d = 1'b1;
          pc_d   = pc_q - 1'b1;
        end
        if (pend_q) begin
          kick_d = 1'b1;
          pc_d   = PC_LOAD;
        end
        // Shutdown outranks disable, fault and any kick about to start.
        if (to_rise) begin
          state_d = S_SHUTDOWN;
          shut_d  = 1'b1;
          kick_d  = 1'b0;
          cnt_d   = '0;
          pc_d    = '0;
        end else if (!enable) begin
          state_d = S_IDLE;
          kick_d  = 1'b0;
          cnt_d   = '0;
          pc_d    = '0;
          miss_d  = '0;
        end else if (term) begin
          if (healthy) begin
            pend_d = 1'b1;
            miss_d = '0;
          end else begin
            miss_d = miss_inc;
            if (miss_inc == MISS_LIM) begin
              state_d = S_FAULT;
              fault_d = 1'b1;
              kick_d  = 1'b0;
              cnt_d   = '0;
              pc_d    = '0;
            end
          end
        end
      end
      S_FAULT: begin
        cnt_d = '0;
        pc_d  = '0;
        if (to_rise) begin
          state_d = S_SHUTDOWN;
          shut_d  = 1'b1;
        end else if (clear) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          miss_d  = '0;
        end
      end
      default: begin
        cnt_d = '0;
        pc_d  = '0;
        if (clear && !wdt_s2_q) begin
          state_d = S_IDLE;
          shut_d  = 1'b0;
          fault_d = 1'b0;
          miss_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      miss_q  <= '0;
      pend_q  <= 1'b0;
      kick_q  <= 1'b0;
      fault_q <= 1'b0;
      shut_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      miss_q  <= miss_d;
      pend_q  <= pend_d;
      kick_q  <= kick_d;
      fault_q <= fault_d;
      shut_q  <= shut_d;
    end
  end

  assign kick         = kick_q;
  assign shutdown_req = shut_q;
  assign fault        = fault_q;
  assign state        = state_q;
  assign miss_cnt     = miss_q;

endmodule
